// File: rtl/vend_pkg.sv
// Shared types and constants for the vending datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Shared between vending_machine and vend_dispenser: FSM state encoding,
// one-hot item codes, and the coin value of a dollar in quarters.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOTOR     = 3'd1,
        WAIT_DROP = 3'd2,
        EJECT     = 3'd3,
        WAIT_ACK  = 3'd4,
        DONE      = 3'd5,
        FAULT     = 3'd6
    } state_t;

    localparam logic [3:0] REFUND = 4'b0001;
    localparam logic [3:0] ITEM_1 = 4'b0010;
    localparam logic [3:0] ITEM_2 = 4'b0100;
    localparam logic [3:0] ITEM_3 = 4'b1000;

    localparam int DOLLAR_Q = 4;
    localparam int AMT_W    = 5;

    // Lowest set item bit, with the refund bit masked off first so a
    // refund-only request yields 4'b0000 (no motor).
    function automatic logic [3:0] pick_item(input logic [3:0] req);
        logic [3:0] m;
        m = req & ~REFUND;
        return m & (~m + 4'd1);
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Clearable up-counter with a terminal flag for the dispenser intervals.
// Latency: o_hit is combinational from the registered count and i_lim.
// Backpressure: none; counts every cycle unless cleared, saturates at all-ones.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clr restarts the
// count at 0 on the next edge; i_lim is the interval length in cycles (>=1);
// o_hit is high on the last cycle of the interval and stays high thereafter.
module dispense_timer #(
    parameter int TMR_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [TMR_W-1:0] i_lim,
    output logic             o_hit
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    // Count starts at 0 on the first cycle of an interval, so the
    // i_lim-th cycle is the one where cnt == i_lim-1.
    assign o_hit = (cnt >= (i_lim - TMR_W'(1)));

endmodule

// File: rtl/vend_dispenser.sv
// Item motor + coin hopper sequencer downstream of vending_machine.
// Latency: motor starts the cycle after a request; all outputs are Moore.
// Backpressure: none upstream; requests while busy are dropped and flagged in o_overrun.
//
// Ports: i_clk, i_rst_n (async active-low); i_item/i_change request from
// vending_machine; i_drop_sense item-drop sensor; i_coin_ack hopper ack.
// o_motor one-hot motor drive; o_eject_dollar/o_eject_quarter coin pulses;
// o_rem_q change left to pay; o_busy, o_done, sticky o_fault and o_overrun.
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 16,
    parameter int TMR_W        = $clog2((MOTOR_CYCLES > ACK_TIMEOUT) ? MOTOR_CYCLES : ACK_TIMEOUT) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_item,
    input  logic [AMT_W-1:0] i_change,
    input  logic             i_drop_sense,
    input  logic             i_coin_ack,
    output logic [3:0]       o_motor,
    output logic             o_eject_dollar,
    output logic             o_eject_quarter,
    output logic [AMT_W-1:0] o_rem_q,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_fault,
    output logic             o_overrun
);

    state_t           state, state_nxt;
    logic [3:0]       item_q, item_nxt, item_sel;
    logic [AMT_W-1:0] rem_q, rem_nxt;
    logic             overrun_q;
    logic             req;
    logic             tmr_clr, tmr_hit;
    logic [TMR_W-1:0] tmr_lim;
    logic             rem_dollar, rem_any;

    assign item_sel   = pick_item(i_item);
    assign req        = (i_item[3:1] != 3'b000) || (i_change != '0);
    assign rem_dollar = (rem_q >= AMT_W'(DOLLAR_Q));
    assign rem_any    = (rem_q != '0);

    // One timer serves every interval: it restarts whenever the state
    // changes, so each state sees a count beginning at 0 on entry.
    assign tmr_clr = (state_nxt != state);
    assign tmr_lim = (state == MOTOR) ? TMR_W'(MOTOR_CYCLES) : TMR_W'(ACK_TIMEOUT);

    dispense_timer #(.TMR_W(TMR_W)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (tmr_clr),
        .i_lim   (tmr_lim),
        .o_hit   (tmr_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            item_q    <= '0;
            rem_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            item_q    <= item_nxt;
            rem_q     <= rem_nxt;
            overrun_q <= overrun_q | (req && (state != IDLE));
        end
    end

    always_comb begin
        state_nxt = state;
        item_nxt  = item_q;
        rem_nxt   = rem_q;
        case (state)
            IDLE: begin
                if (req) begin
                    item_nxt  = item_sel;
                    rem_nxt   = i_change;
                    state_nxt = (item_sel != 4'b0000) ? MOTOR : EJECT;
                end
            end
            MOTOR: begin
                if (tmr_hit) state_nxt = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (i_drop_sense)  state_nxt = EJECT;
                else if (tmr_hit)  state_nxt = FAULT;
            end
            EJECT: begin
                // Guards are checked before subtracting, so rem never wraps.
                if (rem_dollar) begin
                    rem_nxt   = rem_q - AMT_W'(DOLLAR_Q);
                    state_nxt = WAIT_ACK;
                end else if (rem_any) begin
                    rem_nxt   = rem_q - AMT_W'(1);
                    state_nxt = WAIT_ACK;
                end else begin
                    state_nxt = DONE;
                end
            end
            WAIT_ACK: begin
                // Ack wins over a coincident timeout.
                if (i_coin_ack)    state_nxt = EJECT;
                else if (tmr_hit)  state_nxt = FAULT;
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_motor         = (state == MOTOR) ? item_q : 4'b0000;
    assign o_eject_dollar  = (state == EJECT) && rem_dollar;
    assign o_eject_quarter = (state == EJECT) && !rem_dollar && rem_any;
    assign o_rem_q         = rem_q;
    assign o_busy          = (state != IDLE);
    assign o_done          = (state == DONE);
    assign o_fault         = (state == FAULT);
    assign o_overrun       = overrun_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser with a coin/done scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_vend_dispenser;
    import vend_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [3:0]       i_item;
    logic [AMT_W-1:0] i_change;
    logic             i_drop_sense;
    logic             i_coin_ack;
    logic [3:0]       o_motor;
    logic             o_eject_dollar, o_eject_quarter;
    logic [AMT_W-1:0] o_rem_q;
    logic             o_busy, o_done, o_fault, o_overrun;

    vend_dispenser #(.MOTOR_CYCLES(8), .ACK_TIMEOUT(16)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_item          (i_item),
        .i_change        (i_change),
        .i_drop_sense    (i_drop_sense),
        .i_coin_ack      (i_coin_ack),
        .o_motor         (o_motor),
        .o_eject_dollar  (o_eject_dollar),
        .o_eject_quarter (o_eject_quarter),
        .o_rem_q         (o_rem_q),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_fault         (o_fault),
        .o_overrun       (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_D    = 1;
    localparam int K_Q    = 2;
    localparam int K_DONE = 4;

    typedef struct {
        int kind;
        int rem;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic ack_en = 1'b0;
    logic skip_q = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int rem);
        ev_t e;
        e.kind = kind;
        e.rem  = rem;
        sb.push_back(e);
    endtask

    // Expected coin sequence for a change amount: dollars first, then quarters, then done.
    task automatic push_coins(input int n);
        int r;
        r = n;
        while (r >= 4) begin push(K_D, r); r -= 4; end
        while (r >= 1) begin push(K_Q, r); r -= 1; end
        push(K_DONE, 0);
    endtask

    task automatic send(input logic [3:0] item, input int change);
        i_item   = item;
        i_change = AMT_W'(change);
        tick();
        i_item   = 4'b0000;
        i_change = '0;
    endtask

    task automatic motor_run(output int n);
        n = 0;
        while (o_motor != 4'b0000 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic drop_pulse(input int delay);
        repeat (delay) tick();
        i_drop_sense = 1'b1;
        tick();
        i_drop_sense = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (o_busy && k < budget) begin
            k++;
            tick();
        end
        chk(tag, int'(o_busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard: every coin pulse or done pulse pops one expected event;
    // o_rem_q at the pulse is the amount before that coin is subtracted.
    always @(negedge clk) begin
        int obs;
        ev_t e;
        if (rst_n && (o_eject_dollar || o_eject_quarter || o_done)) begin
            obs = (o_eject_dollar ? K_D : 0) + (o_eject_quarter ? K_Q : 0) + (o_done ? K_DONE : 0);
            if (sb.size() == 0) begin
                chk("sb_unexpected_event", obs, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", obs, e.kind);
                chk("sb_rem", int'(o_rem_q), e.rem);
            end
        end
    end

    // Hopper model: ack each coin two cycles after its pulse.
    initial begin
        i_coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && rst_n && (o_eject_dollar || (o_eject_quarter && !skip_q))) begin
                @(posedge clk);
                @(posedge clk);
                #1 i_coin_ack = 1'b1;
                @(posedge clk);
                #1 i_coin_ack = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        i_item       = 4'b0000;
        i_change     = '0;
        i_drop_sense = 1'b0;
        tick();

        // Reset state
        chk("rst_motor",   int'(o_motor), 0);
        chk("rst_ejd",     int'(o_eject_dollar), 0);
        chk("rst_ejq",     int'(o_eject_quarter), 0);
        chk("rst_rem",     int'(o_rem_q), 0);
        chk("rst_busy",    int'(o_busy), 0);
        chk("rst_done",    int'(o_done), 0);
        chk("rst_fault",   int'(o_fault), 0);
        chk("rst_overrun", int'(o_overrun), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Item only, no change
        push_coins(0);
        send(ITEM_1, 0);
        chk("t1_motor_val", int'(o_motor), int'(ITEM_1));
        motor_run(n);
        chk("t1_motor_cycles", n, 8);
        drop_pulse(3);
        wait_idle("t1_idle", 20);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_fault", int'(o_fault), 0);

        // Item with 7 quarters change: D,Q,Q,Q
        ack_en = 1'b1;
        push_coins(7);
        send(ITEM_2, 7);
        chk("t2_motor_val", int'(o_motor), int'(ITEM_2));
        motor_run(n);
        chk("t2_motor_cycles", n, 8);
        drop_pulse(0);
        wait_idle("t2_idle", 100);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_rem_end", int'(o_rem_q), 0);
        chk("t2_fault", int'(o_fault), 0);

        // Refund of 10: no motor, D,D,Q,Q
        push_coins(10);
        send(REFUND, 10);
        chk("t3_no_motor", int'(o_motor), 0);
        chk("t3_busy", int'(o_busy), 1);
        wait_idle("t3_idle", 100);
        chk("t3_sb_empty", sb.size(), 0);

        // Max refund 31 with a second request during WAIT_ACK
        push_coins(31);
        send(REFUND, 31);
        tick();
        chk("t6_pre_overrun", int'(o_overrun), 0);
        send(ITEM_1, 3);
        chk("t6_overrun", int'(o_overrun), 1);
        wait_idle("t6_idle", 200);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_fault", int'(o_fault), 0);
        chk("t6_rem_end", int'(o_rem_q), 0);

        // Drop timeout: fault after 8 motor + 16 wait cycles
        do_reset();
        chk("t4_overrun_cleared", int'(o_overrun), 0);
        send(ITEM_3, 0);
        chk("t4_motor_val", int'(o_motor), int'(ITEM_3));
        repeat (23) tick();
        chk("t4_fault_early", int'(o_fault), 0);
        tick();
        chk("t4_fault", int'(o_fault), 1);
        chk("t4_motor_off", int'(o_motor), 0);
        chk("t4_busy", int'(o_busy), 1);
        send(ITEM_1, 1);
        chk("t4_overrun", int'(o_overrun), 1);
        repeat (5) tick();
        chk("t4_fault_sticky", int'(o_fault), 1);
        chk("t4_busy_sticky", int'(o_busy), 1);

        // Hopper stall on the quarter
        do_reset();
        skip_q = 1'b1;
        push(K_D, 5);
        push(K_Q, 1);
        send(REFUND, 5);
        n = 0;
        while (!o_eject_quarter && n < 50) begin
            n++;
            tick();
        end
        chk("t5_quarter_seen", int'(o_eject_quarter), 1);
        repeat (16) tick();
        chk("t5_fault_early", int'(o_fault), 0);
        tick();
        chk("t5_fault", int'(o_fault), 1);
        chk("t5_rem_frozen", int'(o_rem_q), 0);
        chk("t5_busy", int'(o_busy), 1);
        chk("t5_sb_empty", sb.size(), 0);

        // Reset mid-MOTOR, then a fresh transaction
        do_reset();
        skip_q = 1'b0;
        send(ITEM_2, 0);
        repeat (3) tick();
        chk("t7_motor_before", int'(o_motor), int'(ITEM_2));
        rst_n = 1'b0;
        #1;
        chk("t7_motor_rst", int'(o_motor), 0);
        chk("t7_busy_rst", int'(o_busy), 0);
        chk("t7_rem_rst", int'(o_rem_q), 0);
        chk("t7_fault_rst", int'(o_fault), 0);
        tick();
        rst_n = 1'b1;
        tick();
        push_coins(1);
        send(ITEM_2, 1);
        chk("t7_motor_new", int'(o_motor), int'(ITEM_2));
        motor_run(n);
        chk("t7_motor_cycles", n, 8);
        drop_pulse(1);
        wait_idle("t7_idle", 50);
        chk("t7_sb_empty", sb.size(), 0);
        chk("t7_fault", int'(o_fault), 0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
